// File: rtl/snake_core.sv
// rtl/snake_core.sv - snake game engine: ring-buffer body, tick-driven moves, self-collision scan
//
// Optional feature macro: SNAKE_WRAP_EN (border cells playable, moves wrap
// around the grid edges, no wall game-over). Undefined: border cells are walls.
//
// Ports:
//   i_Clk, i_Rst            clock, synchronous active-low reset
//   i_Start                 begin/restart a game (honoured in IDLE or OVER)
//   i_Tick, i_Pause         move strobe, pause level
//   i_Dir, i_Dir_Valid      pending direction (0 up, 1 down, 2 left, 3 right)
//   i_Item_x/y, i_Item_Valid  item cell from the item generator
//   i_Rd_Idx                renderer segment index (0 = head)
//   o_Rd_x/y, o_Rd_Valid    registered segment read result
//   o_Head_x/y, o_Len, o_Score, o_Eat, o_Over, o_State  game status
module snake_core #(
    parameter int XSIZE   = 48,
    parameter int YSIZE   = 64,
    parameter int CW      = 6,
    parameter int MAX_LEN = 32,
    parameter int DEF_LEN = 3,
    localparam int IW     = $clog2(MAX_LEN)
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    input  logic          i_Start,
    input  logic          i_Tick,
    input  logic          i_Pause,
    input  logic [1:0]    i_Dir,
    input  logic          i_Dir_Valid,
    input  logic [CW-1:0] i_Item_x,
    input  logic [CW-1:0] i_Item_y,
    input  logic          i_Item_Valid,
    input  logic [IW-1:0] i_Rd_Idx,
    output logic [CW-1:0] o_Rd_x,
    output logic [CW-1:0] o_Rd_y,
    output logic          o_Rd_Valid,
    output logic [CW-1:0] o_Head_x,
    output logic [CW-1:0] o_Head_y,
    output logic [IW:0]   o_Len,
    output logic [15:0]   o_Score,
    output logic          o_Eat,
    output logic          o_Over,
    output logic [2:0]    o_State
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_MOVE   = 3'd3;
    localparam logic [2:0] S_SCAN   = 3'd4;
    localparam logic [2:0] S_COMMIT = 3'd5;
    localparam logic [2:0] S_OVER   = 3'd6;

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    localparam logic [CW-1:0] X_MID  = CW'(XSIZE / 2);
    localparam logic [CW-1:0] Y_MID  = CW'(YSIZE / 2);
    localparam logic [CW-1:0] X_LAST = CW'(XSIZE - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(YSIZE - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    localparam logic [IW:0]   LEN_MAX = (IW+1)'(MAX_LEN);
    localparam logic [IW:0]   LEN_DEF = (IW+1)'(DEF_LEN);
    localparam logic [IW:0]   LEN_ONE = (IW+1)'(1);
    localparam logic [IW-1:0] K_ONE   = IW'(1);
    localparam logic [IW-1:0] K_INIT_LAST = IW'(DEF_LEN - 1);

    logic [CW-1:0] mem_x [MAX_LEN];
    logic [CW-1:0] mem_y [MAX_LEN];

    logic [2:0]    state;
    logic [IW:0]   len;
    logic [15:0]   score;
    logic [IW-1:0] ptr;
    logic [IW-1:0] cnt;
    logic [1:0]    dir;
    logic [1:0]    pdir;
    logic [CW-1:0] head_x, head_y;
    logic [CW-1:0] nxt_x, nxt_y;
    logic          grow;
    logic [CW-1:0] rd_x, rd_y;
    logic          rd_valid;
    logic          eat;

    // Direction actually used by the next move: a reversal would fold the
    // head onto the neck, so it is refused whenever there is a neck.
    logic [1:0]    eff_dir;
    logic [CW-1:0] cand_x, cand_y;
    logic          wall;
    logic [IW-1:0] seg_addr;
    logic          hit;
    logic          at_tail;

    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic [CW-1:0] wr_x, wr_y;

    assign eff_dir = ((pdir == (dir ^ 2'b01)) && (len > LEN_ONE)) ? dir : pdir;

    always_comb begin
        cand_x = head_x;
        cand_y = head_y;
        case (eff_dir)
`ifdef SNAKE_WRAP_EN
            D_UP:    cand_y = (head_y == '0)     ? Y_LAST : head_y - C_ONE;
            D_DOWN:  cand_y = (head_y == Y_LAST) ? '0     : head_y + C_ONE;
            D_LEFT:  cand_x = (head_x == '0)     ? X_LAST : head_x - C_ONE;
            default: cand_x = (head_x == X_LAST) ? '0     : head_x + C_ONE;
`else
            D_UP:    cand_y = head_y - C_ONE;
            D_DOWN:  cand_y = head_y + C_ONE;
            D_LEFT:  cand_x = head_x - C_ONE;
            default: cand_x = head_x + C_ONE;
`endif
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign wall = 1'b0;
`else
    assign wall = (cand_x == '0) || (cand_x == X_LAST) ||
                  (cand_y == '0) || (cand_y == Y_LAST);
`endif

    // Segment k lives at mem[ptr - k]; cnt doubles as the INIT write index
    // and the SCAN compare index.
    assign seg_addr = ptr - cnt;
    assign hit      = (mem_x[seg_addr] == nxt_x) && (mem_y[seg_addr] == nxt_y);
    assign at_tail  = ({1'b0, cnt} == (len - LEN_ONE));

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = seg_addr;
        wr_x    = X_MID - CW'(cnt);
        wr_y    = Y_MID;
        if (state == S_INIT) begin
            wr_en = 1'b1;
        end else if (state == S_COMMIT) begin
            wr_en   = 1'b1;
            wr_addr = ptr + K_ONE;
            wr_x    = nxt_x;
            wr_y    = nxt_y;
        end
    end

    // Body storage needs no reset: entries beyond the live length are
    // never exposed and INIT rewrites the live ones.
    always_ff @(posedge i_Clk) begin
        if (wr_en) begin
            mem_x[wr_addr] <= wr_x;
            mem_y[wr_addr] <= wr_y;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            state    <= S_IDLE;
            len      <= '0;
            score    <= '0;
            ptr      <= '0;
            cnt      <= '0;
            dir      <= D_RIGHT;
            pdir     <= D_RIGHT;
            head_x   <= X_MID;
            head_y   <= Y_MID;
            nxt_x    <= '0;
            nxt_y    <= '0;
            grow     <= 1'b0;
            rd_x     <= '0;
            rd_y     <= '0;
            rd_valid <= 1'b0;
            eat      <= 1'b0;
        end else begin
            eat <= 1'b0;
            if (i_Dir_Valid) begin
                pdir <= i_Dir;
            end
            // Sampled before any COMMIT update, so a read in COMMIT sees
            // the pre-commit body.
            rd_x     <= mem_x[ptr - i_Rd_Idx];
            rd_y     <= mem_y[ptr - i_Rd_Idx];
            rd_valid <= ({1'b0, i_Rd_Idx} < len);

            case (state)
                S_IDLE, S_OVER: begin
                    if (i_Start) begin
                        state <= S_INIT;
                        cnt   <= '0;
                    end
                end
                S_INIT: begin
                    if (cnt == '0) begin
                        head_x <= X_MID;
                        head_y <= Y_MID;
                    end
                    if (cnt == K_INIT_LAST) begin
                        state <= S_RUN;
                        len   <= LEN_DEF;
                        score <= '0;
                        dir   <= D_RIGHT;
                    end else begin
                        cnt <= cnt + K_ONE;
                    end
                end
                S_RUN: begin
                    if (i_Tick && !i_Pause) begin
                        state <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    dir   <= eff_dir;
                    nxt_x <= cand_x;
                    nxt_y <= cand_y;
                    grow  <= i_Item_Valid && (cand_x == i_Item_x) && (cand_y == i_Item_y);
                    cnt   <= '0;
                    state <= wall ? S_OVER : S_SCAN;
                end
                S_SCAN: begin
                    // The tail cell is vacated by a non-growing move, so
                    // landing on it is legal.
                    if (hit && !(at_tail && !grow)) begin
                        state <= S_OVER;
                    end else if (at_tail) begin
                        state <= S_COMMIT;
                    end else begin
                        cnt <= cnt + K_ONE;
                    end
                end
                S_COMMIT: begin
                    ptr    <= ptr + K_ONE;
                    head_x <= nxt_x;
                    head_y <= nxt_y;
                    if (grow) begin
                        eat <= 1'b1;
                        if (len < LEN_MAX) begin
                            len <= len + LEN_ONE;
                        end
                        if (score != 16'hFFFF) begin
                            score <= score + 16'd1;
                        end
                    end
                    state <= S_RUN;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_Rd_x     = rd_x;
    assign o_Rd_y     = rd_y;
    assign o_Rd_Valid = rd_valid;
    assign o_Head_x   = head_x;
    assign o_Head_y   = head_y;
    assign o_Len      = len;
    assign o_Score    = score;
    assign o_Eat      = eat;
    assign o_Over     = (state == S_OVER);
    assign o_State    = state;

endmodule

// File: tb/tb_snake_core.sv
// tb/tb_snake_core.sv - self-checking bench for snake_core
module tb_snake_core;

    localparam int CW = 6;
    localparam int IW = 5;
    localparam int ST_IDLE = 0;
    localparam int ST_INIT = 1;
    localparam int ST_RUN  = 2;
    localparam int ST_SCAN = 4;
    localparam int ST_OVER = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          tick = 1'b0;
    logic          pause = 1'b0;
    logic [1:0]    dir = 2'd3;
    logic          dir_valid = 1'b0;
    logic [CW-1:0] item_x = '0;
    logic [CW-1:0] item_y = '0;
    logic          item_valid = 1'b0;
    logic [IW-1:0] rd_idx = '0;
    logic [CW-1:0] rd_x, rd_y;
    logic          rd_valid;
    logic [CW-1:0] head_x, head_y;
    logic [IW:0]   len;
    logic [15:0]   score;
    logic          eat;
    logic          over;
    logic [2:0]    state;

    int total = 0;
    int bad   = 0;

    snake_core #(
        .XSIZE(48), .YSIZE(64), .CW(CW), .MAX_LEN(32), .DEF_LEN(3)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Tick(tick),
        .i_Pause(pause), .i_Dir(dir), .i_Dir_Valid(dir_valid),
        .i_Item_x(item_x), .i_Item_y(item_y), .i_Item_Valid(item_valid),
        .i_Rd_Idx(rd_idx), .o_Rd_x(rd_x), .o_Rd_y(rd_y), .o_Rd_Valid(rd_valid),
        .o_Head_x(head_x), .o_Head_y(head_y), .o_Len(len), .o_Score(score),
        .o_Eat(eat), .o_Over(over), .o_State(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit restart;
        bit dv;
        int d;
        bit iv;
        int ix, iy;
        int ex, ey;
        int elen, escore;
        bit eover, eeat;
        int ecyc;
    } move_t;

    move_t tbl[12];
    move_t sb[$];

    function automatic move_t mk(bit rs, bit dv, int d, bit iv, int ix, int iy,
                                 int ex, int ey, int el, int es, bit eo, bit ee, int ec);
        move_t m;
        m.restart = rs; m.dv = dv; m.d = d; m.iv = iv; m.ix = ix; m.iy = iy;
        m.ex = ex; m.ey = ey; m.elen = el; m.escore = es;
        m.eover = eo; m.eeat = ee; m.ecyc = ec;
        return m;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game();
        start = 1'b1;
        step();
        start = 1'b0;
        check("init_state", int'(state), ST_INIT);
        repeat (3) @(posedge clk);
        #1;
        check("run_after_init", int'(state), ST_RUN);
        check("init_len", int'(len), 3);
        check("init_score", int'(score), 0);
    endtask

    task automatic read_check(input int idx, input int ex, input int ey, input bit ev);
        rd_idx = IW'(idx);
        step();
        check($sformatf("rd_valid[%0d]", idx), int'(rd_valid), int'(ev));
        if (ev) begin
            check($sformatf("rd_x[%0d]", idx), int'(rd_x), ex);
            check($sformatf("rd_y[%0d]", idx), int'(rd_y), ey);
        end
    endtask

    // Drives one tick, pushes the expectation, then waits (bounded) for the
    // move to settle in RUN or OVER and pops/compares.
    task automatic run_move(input move_t m);
        move_t e;
        int n_done;
        int nh_x, nh_y;
        if (m.restart) start_game();
        dir        = 2'(m.d);
        dir_valid  = m.dv;
        item_valid = m.iv;
        item_x     = CW'(m.ix);
        item_y     = CW'(m.iy);
        tick       = 1'b1;
        sb.push_back(m);
        step();
        dir_valid = 1'b0;
        tick      = 1'b0;
        n_done    = -1;
        for (int n = 1; n <= 80; n++) begin
            if (int'(state) == ST_RUN || int'(state) == ST_OVER) begin
                n_done = n;
                break;
            end
            // Stray tick and start mid-move must both be dropped.
            if (n == 2 && !m.eover) begin
                tick  = 1'b1;
                start = 1'b1;
            end
            if (n == 3) begin
                tick  = 1'b0;
                start = 1'b0;
            end
            step();
        end
        tick  = 1'b0;
        start = 1'b0;
        e = sb.pop_front();
        check("move_cycles", n_done, e.ecyc);
        check("head_x", int'(head_x), e.ex);
        check("head_y", int'(head_y), e.ey);
        check("len", int'(len), e.elen);
        check("score", int'(score), e.escore);
        check("over", int'(over), int'(e.eover));
        check("eat", int'(eat), int'(e.eeat));
        if (!e.eover) begin
            nh_x = int'(head_x);
            nh_y = int'(head_y);
            step();
            check("eat_one_cycle", int'(eat), 0);
            step();
            check("no_queued_tick", int'(state), ST_RUN);
            check("head_stable", int'(head_x) * 100 + int'(head_y), nh_x * 100 + nh_y);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

        // Game 1: reversal rejection, turns, two eats, self-hit.
        tbl[0]  = mk(0, 1, 2, 0,  0,  0, 25, 32, 3, 0, 0, 0, 6);
        tbl[1]  = mk(0, 1, 0, 1, 40, 40, 25, 31, 3, 0, 0, 0, 6);
        tbl[2]  = mk(0, 1, 3, 1, 26, 31, 26, 31, 4, 1, 0, 1, 6);
        tbl[3]  = mk(0, 0, 3, 1, 27, 31, 27, 31, 5, 2, 0, 1, 7);
        tbl[4]  = mk(0, 1, 0, 0,  0,  0, 27, 30, 5, 2, 0, 0, 8);
        tbl[5]  = mk(0, 1, 2, 0,  0,  0, 26, 30, 5, 2, 0, 0, 8);
        tbl[6]  = mk(0, 1, 1, 0,  0,  0, 26, 30, 5, 2, 1, 0, 6);
        // Game 2: restart from OVER, moves into the vacating tail cell.
        tbl[7]  = mk(1, 1, 3, 1, 25, 32, 25, 32, 4, 1, 0, 1, 6);
        tbl[8]  = mk(0, 1, 0, 0,  0,  0, 25, 31, 4, 1, 0, 0, 7);
        tbl[9]  = mk(0, 1, 2, 0,  0,  0, 24, 31, 4, 1, 0, 0, 7);
        tbl[10] = mk(0, 1, 1, 0,  0,  0, 24, 32, 4, 1, 0, 0, 7);
        tbl[11] = mk(0, 1, 3, 0,  0,  0, 25, 32, 4, 1, 0, 0, 7);

        repeat (3) @(posedge clk);
        #1;
        check("rst_state", int'(state), ST_IDLE);
        check("rst_len", int'(len), 0);
        check("rst_score", int'(score), 0);
        check("rst_head_x", int'(head_x), 24);
        check("rst_head_y", int'(head_y), 32);
        check("rst_over", int'(over), 0);
        check("rst_eat", int'(eat), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_x", int'(rd_x), 0);
        rst = 1'b1;
        step();

        start_game();
        read_check(0, 24, 32, 1);
        read_check(1, 23, 32, 1);
        read_check(2, 22, 32, 1);
        read_check(3, 0, 0, 0);

        // Tick while paused is dropped, not queued.
        pause = 1'b1;
        tick  = 1'b1;
        step();
        tick = 1'b0;
        repeat (5) step();
        check("pause_state", int'(state), ST_RUN);
        check("pause_head", int'(head_x), 24);
        pause = 1'b0;
        step();
        check("pause_not_queued", int'(state), ST_RUN);

        for (int i = 0; i < 12; i++) begin
            if (i == 7) begin
                // Body frozen and readable in OVER after the self-hit.
                read_check(0, 26, 30, 1);
                read_check(4, 25, 31, 1);
                read_check(5, 0, 0, 0);
            end
            run_move(tbl[i]);
        end

        // Straight run right from x=25 toward the east border.
        for (int x = 26; x <= 46; x++) begin
            run_move(mk(0, 0, 3, 0, 0, 0, x, 32, 4, 1, 0, 0, 7));
        end
`ifdef SNAKE_WRAP_EN
        run_move(mk(0, 0, 3, 0, 0, 0, 47, 32, 4, 1, 0, 0, 7));
        run_move(mk(0, 0, 3, 0, 0, 0, 0, 32, 4, 1, 0, 0, 7));
`else
        run_move(mk(0, 0, 3, 0, 0, 0, 46, 32, 4, 1, 1, 0, 2));
`endif

        // Reset in the middle of a SCAN.
        rst = 1'b0;
        step();
        rst = 1'b1;
        item_valid = 1'b0;
        start_game();
        tick = 1'b1;
        step();
        tick  = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (int'(state) == ST_SCAN) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("reach_scan", int'(found), 1);
        rst = 1'b0;
        step();
        check("midscan_rst_state", int'(state), ST_IDLE);
        check("midscan_rst_len", int'(len), 0);
        rst = 1'b1;
        start_game();
        read_check(0, 24, 32, 1);
        read_check(1, 23, 32, 1);
        read_check(2, 22, 32, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
